// File: rtl/vga_timing_gen.sv
// VGA 640x480 timing generator: pixel-rate divider, h/v counters, sync and
// blanking decode, plus frame and game-rate tick generation.
module vga_timing_gen #(
  parameter int unsigned CLK_DIV  = 4,
  parameter int unsigned GAME_DIV = 6
) (
  input  logic        clk,
  input  logic        rst,
  output logic        pix_en,
  output logic [9:0]  hCount,
  output logic [9:0]  vCount,
  output logic        hSync,
  output logic        vSync,
  output logic        bright,
  output logic        frame_tick,
  output logic        game_tick,
  output logic [15:0] frame_count
);

  localparam int unsigned DivW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DivW-1:0] DivLast  = DivW'(CLK_DIV - 1);
  localparam logic [9:0]      HLast    = 10'd799;
  localparam logic [9:0]      VLast    = 10'd524;
  localparam logic [7:0]      GameLast = 8'(GAME_DIV - 1);

  logic [DivW-1:0] div_q, div_d;
  logic            pix_en_q, pix_en_d;
  logic [9:0]      h_count_q, h_count_d;
  logic [9:0]      v_count_q, v_count_d;
  logic            frame_tick_q, frame_tick_d;
  logic            game_tick_q, game_tick_d;
  logic [15:0]     frame_count_q, frame_count_d;
  logic [7:0]      game_sub_q, game_sub_d;

  logic h_wrap;
  logic frame_wrap;

  // Next-state logic for the divider, raster counters and frame/game ticks.
  always_comb begin
    div_d         = div_q;
    pix_en_d      = 1'b0;
    h_count_d     = h_count_q;
    v_count_d     = v_count_q;
    frame_tick_d  = 1'b0;
    game_tick_d   = 1'b0;
    frame_count_d = frame_count_q;
    game_sub_d    = game_sub_q;

    div_d    = (div_q == DivLast) ? '0 : div_q + 1'b1;
    pix_en_d = (div_q == DivLast);

    h_wrap     = pix_en_q && (h_count_q == HLast);
    frame_wrap = h_wrap && (v_count_q == VLast);

    if (pix_en_q) begin
      h_count_d = h_wrap ? 10'd0 : h_count_q + 10'd1;
    end
    if (h_wrap) begin
      v_count_d = (v_count_q == VLast) ? 10'd0 : v_count_q + 10'd1;
    end

    // Frame bookkeeping updates on the same edge the counters return to 0,0,
    // so frame_tick, game_tick and the new frame_count appear together.
    if (frame_wrap) begin
      frame_tick_d  = 1'b1;
      frame_count_d = frame_count_q + 16'd1;
      if (game_sub_q == GameLast) begin
        game_sub_d  = 8'd0;
        game_tick_d = 1'b1;
      end else begin
        game_sub_d  = game_sub_q + 8'd1;
      end
    end
  end

  // State registers; synchronous reset overrides any simultaneous event.
  always_ff @(posedge clk) begin
    if (rst) begin
      div_q         <= '0;
      pix_en_q      <= 1'b0;
      h_count_q     <= 10'd0;
      v_count_q     <= 10'd0;
      frame_tick_q  <= 1'b0;
      game_tick_q   <= 1'b0;
      frame_count_q <= 16'd0;
      game_sub_q    <= 8'd0;
    end else begin
      div_q         <= div_d;
      pix_en_q      <= pix_en_d;
      h_count_q     <= h_count_d;
      v_count_q     <= v_count_d;
      frame_tick_q  <= frame_tick_d;
      game_tick_q   <= game_tick_d;
      frame_count_q <= frame_count_d;
      game_sub_q    <= game_sub_d;
    end
  end

  // Zero-latency decode of sync and visible window from the registered counters.
  always_comb begin
    hSync  = (h_count_q >= 10'd96);
    vSync  = (v_count_q >= 10'd2);
    bright = (h_count_q >= 10'd144) && (h_count_q <= 10'd783) &&
             (v_count_q >= 10'd35)  && (v_count_q <= 10'd514);
  end

  assign pix_en      = pix_en_q;
  assign hCount      = h_count_q;
  assign vCount      = v_count_q;
  assign frame_tick  = frame_tick_q;
  assign game_tick   = game_tick_q;
  assign frame_count = frame_count_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Self-checking bench for vga_timing_gen: a pixel-index reference model checks
// every output each cycle; directed steps cover the line, frame, game-tick,
// mid-frame reset and frame_count wrap behaviour. Counters are preloaded with
// force so whole frames need not be simulated.
module tb_vga_timing_gen;

  localparam int unsigned ClkDiv   = 4;
  localparam int unsigned GameDiv  = 6;
  localparam int          FramePix = 800 * 525;

  logic        clk;
  logic        rst;
  logic        pix_en;
  logic [9:0]  hCount;
  logic [9:0]  vCount;
  logic        hSync;
  logic        vSync;
  logic        bright;
  logic        frame_tick;
  logic        game_tick;
  logic [15:0] frame_count;

  vga_timing_gen #(
    .CLK_DIV  (ClkDiv),
    .GAME_DIV (GameDiv)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .pix_en      (pix_en),
    .hCount      (hCount),
    .vCount      (vCount),
    .hSync       (hSync),
    .vSync       (vSync),
    .bright      (bright),
    .frame_tick  (frame_tick),
    .game_tick   (game_tick),
    .frame_count (frame_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks;
  int failures;

  // Reference model: clocks since reset and linear pixel index within a frame.
  int          m_n;
  bit          m_pe;
  int          m_p;
  bit          m_ft;
  bit          m_gt;
  int          m_frames;
  logic [15:0] m_fc;

  // Preload values (module scope so they can drive force statements).
  logic [9:0]  f_h;
  logic [9:0]  f_v;
  logic [15:0] f_fc;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int m_h();
    return m_p % 800;
  endfunction

  function automatic int m_v();
    return m_p / 800;
  endfunction

  // One clock edge: advance the model, then compare every output after the edge.
  task automatic tick();
    @(posedge clk);
    if (rst) begin
      m_n = 0; m_pe = 0; m_p = 0; m_ft = 0; m_gt = 0; m_frames = 0; m_fc = 16'd0;
    end else begin
      m_ft = 0;
      m_gt = 0;
      if (m_pe) begin
        m_p = (m_p + 1) % FramePix;
        if (m_p == 0) begin
          m_ft = 1;
          m_frames++;
          m_fc = m_fc + 16'd1;
          m_gt = (m_frames % GameDiv) == 0;
        end
      end
      m_n++;
      m_pe = (m_n % ClkDiv) == 0;
    end
    #1;
    check("pix_en", 32'(pix_en), 32'(m_pe));
    check("hCount", 32'(hCount), 32'(m_h()));
    check("vCount", 32'(vCount), 32'(m_v()));
    check("hSync", 32'(hSync), 32'(!(m_h() < 96)));
    check("vSync", 32'(vSync), 32'(!(m_v() < 2)));
    check("bright", 32'(bright),
          32'((m_h() >= 144) && (m_h() <= 783) && (m_v() >= 35) && (m_v() <= 514)));
    check("frame_tick", 32'(frame_tick), 32'(m_ft));
    check("game_tick", 32'(game_tick), 32'(m_gt));
    check("frame_count", 32'(frame_count), 32'(m_fc));
  endtask

  // Hold the raster counters (and optionally frame_count) across an edge with
  // no pixel enable so the registers capture the preloaded values.
  task automatic preload(input int h, input int v, input bit set_fc, input int fc);
    if (m_pe) tick();
    f_h  = 10'(h);
    f_v  = 10'(v);
    f_fc = 16'(fc);
    force dut.h_count_q = f_h;
    force dut.v_count_q = f_v;
    if (set_fc) force dut.frame_count_q = f_fc;
    m_p = v * 800 + h;
    if (set_fc) m_fc = 16'(fc);
    tick();
    release dut.h_count_q;
    release dut.v_count_q;
    if (set_fc) release dut.frame_count_q;
  endtask

  // Run until the model expects a frame_tick, with a cycle budget.
  task automatic run_to_frame(input string tag, output bit seen_gt);
    bit done;
    done    = 0;
    seen_gt = 0;
    for (int i = 0; i < 200 && !done; i++) begin
      tick();
      if (m_ft) begin
        done    = 1;
        seen_gt = game_tick;
      end
    end
    if (!done) check({tag, "_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic do_reset(input int cycles);
    rst = 1'b1;
    repeat (cycles) tick();
    rst = 1'b0;
  endtask

  initial begin
    int cnt;
    int first_pe;
    bit gt;
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    f_h = '0; f_v = '0; f_fc = '0;
    m_n = 0; m_pe = 0; m_p = 0; m_ft = 0; m_gt = 0; m_frames = 0; m_fc = 16'd0;

    // Reset state, then first pix_en exactly ClkDiv clocks after release.
    do_reset(2);
    check("reset_hSync", 32'(hSync), 32'd0);
    check("reset_bright", 32'(bright), 32'd0);
    first_pe = 0;
    for (int i = 1; i <= 12; i++) begin
      tick();
      if (pix_en && first_pe == 0) first_pe = i;
    end
    check("first_pix_en_clk", 32'(first_pe), 32'(ClkDiv));

    // Second full line: 3200 clocks long, hSync low for 384 of them.
    for (int i = 0; i < 4000 && m_p != 800; i++) tick();
    check("line1_start_h", 32'(hCount), 32'd0);
    check("line1_start_v", 32'(vCount), 32'd1);
    cnt = hSync ? 0 : 1;
    repeat (3199) begin
      tick();
      if (!hSync) cnt++;
    end
    check("line_end_v", 32'(vCount), 32'd1);
    tick();
    check("line2_start_v", 32'(vCount), 32'd2);
    check("line2_start_h", 32'(hCount), 32'd0);
    check("hsync_low_clks", 32'(cnt), 32'd384);

    // First visible pixel at hCount 144, vCount 35.
    preload(142, 35, 0, 0);
    for (int i = 0; i < 40 && m_h() != 144; i++) tick();
    check("bright_first", 32'(bright), 32'd1);

    // Twelve frames: game_tick only on frames 6 and 12, with frame_tick.
    do_reset(1);
    for (int k = 1; k <= 12; k++) begin
      preload(796, 524, 0, 0);
      run_to_frame("frame", gt);
      check("frame_tick_at_wrap", 32'(frame_tick), 32'd1);
      check("wrap_counters_zero", 32'({hCount, vCount}), 32'd0);
      check("game_tick_frame", 32'(gt), 32'((k % 6) == 0));
    end
    check("frame_count_12", 32'(frame_count), 32'd12);

    // Reset for one clock mid-frame clears everything, no frame_tick afterwards.
    preload(500, 300, 0, 0);
    repeat (3) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst_h", 32'(hCount), 32'd0);
    check("midrst_v", 32'(vCount), 32'd0);
    check("midrst_hSync", 32'(hSync), 32'd0);
    check("midrst_fc", 32'(frame_count), 32'd0);
    cnt = 0;
    repeat (3 * ClkDiv) begin
      tick();
      if (frame_tick) cnt++;
    end
    check("midrst_no_frame_tick", 32'(cnt), 32'd0);

    // frame_count wraps 65535 -> 0.
    preload(797, 524, 1, 65535);
    run_to_frame("fc_wrap", gt);
    check("frame_count_wrap", 32'(frame_count), 32'd0);

    // Randomized segments: random preloads, reset pulses and run lengths.
    for (int s = 0; s < 30; s++) begin
      case ($urandom_range(0, 3))
        0: preload($urandom_range(0, 799), $urandom_range(0, 524), 0, 0);
        1: preload($urandom_range(780, 799), $urandom_range(520, 524),
                   $urandom_range(0, 1), $urandom_range(65530, 65535));
        2: do_reset($urandom_range(1, 3));
        default: repeat ($urandom_range(20, 200)) tick();
      endcase
      repeat ($urandom_range(5, 60)) tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
